// File: rtl/lw_sha_core_arbiter.sv
// lw_sha_core_arbiter: whole-message round-robin arbiter that shares one lw_hmac core.
// Define LW_SHA_ARB_WATCHDOG_EN to enable the BUSY idle watchdog (err_o abort pulse).
module lw_sha_core_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ARCH_SZ = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  output logic [N_REQ-1:0]         gnt_o,
  input  logic [N_REQ-1:0]         start_i,
  input  logic [N_REQ-1:0]         valid_i,
  input  logic [N_REQ-1:0]         last_i,
  input  logic [N_REQ-1:0]         abort_i,
  input  logic [N_REQ*ARCH_SZ-1:0] data_i,
  input  logic [N_REQ*4-1:0]       opcode_i,
  output logic [N_REQ-1:0]         ready_o,
  output logic [N_REQ-1:0]         done_o,
  output logic [N_REQ-1:0]         err_o,
  output logic                     core_start_o,
  output logic                     core_valid_o,
  output logic                     core_last_o,
  output logic                     core_abort_o,
  output logic [ARCH_SZ-1:0]       core_data_o,
  output logic [3:0]               core_opcode_o,
  input  logic                     core_ready_i,
  input  logic                     core_idle_i,
  input  logic                     core_done_i
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_BUSY, S_ABORT, S_RELEASE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   arb_idx;
  logic [PTR_W-1:0]   cand;
  logic               arb_found;
  logic               accept;
  logic               wd_expire;
  logic [ARCH_SZ-1:0] data_a [N_REQ];
  logic [3:0]         op_a   [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_a[gi] = data_i[gi*ARCH_SZ +: ARCH_SZ];
    assign op_a[gi]   = opcode_i[gi*4 +: 4];
  end

  // Round-robin search: first requester above the last grant, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      cand = PTR_W'((32'(ptr) + 32'(i)) % N_REQ);
      if (!arb_found && req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign accept = (state == S_BUSY) && valid_i[ptr] && core_ready_i;

`ifdef LW_SHA_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == S_BUSY) && !accept && (wd_cnt == WD_W'(TIMEOUT - 1));

  // Idle-cycle counter, restarted on BUSY entry and on each accepted word.
  always_ff @(posedge clk_i) begin
    if (rst_i || state != S_BUSY || accept) wd_cnt <= '0;
    else                                    wd_cnt <= wd_cnt + 1'b1;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign wd_expire      = 1'b0;
`endif

  // Core-side mux: only the granted requester reaches the core, only in GRANT/BUSY.
  always_comb begin
    core_start_o  = 1'b0;
    core_valid_o  = 1'b0;
    core_last_o   = 1'b0;
    core_abort_o  = 1'b0;
    core_data_o   = '0;
    core_opcode_o = '0;
    ready_o       = '0;
    if (state == S_GRANT || state == S_BUSY) begin
      core_data_o   = data_a[ptr];
      core_opcode_o = op_a[ptr];
    end
    if (state == S_GRANT) core_start_o = core_idle_i & start_i[ptr];
    if (state == S_BUSY) begin
      core_valid_o = valid_i[ptr];
      core_last_o  = last_i[ptr];
      ready_o      = gnt_o & {N_REQ{core_ready_i}};
      core_abort_o = ~core_done_i & (abort_i[ptr] | wd_expire);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      ptr    <= PTR_W'(N_REQ - 1);
      gnt_o  <= '0;
      done_o <= '0;
      err_o  <= '0;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state)
        S_IDLE, S_RELEASE: begin
          gnt_o <= '0;
          state <= S_IDLE;
          if (arb_found) begin
            gnt_o <= N_REQ'(1) << arb_idx;
            ptr   <= arb_idx;
            state <= S_GRANT;
          end
        end
        S_GRANT: if (core_start_o) state <= S_BUSY;
        S_BUSY: begin
          // Done has priority over a same-cycle abort.
          if (core_done_i) begin
            done_o <= gnt_o;
            gnt_o  <= '0;
            state  <= S_RELEASE;
          end else if (abort_i[ptr]) begin
            state <= S_ABORT;
          end else if (wd_expire) begin
            err_o <= gnt_o;
            state <= S_ABORT;
          end
        end
        S_ABORT: begin
          if (core_idle_i) begin
            gnt_o <= '0;
            state <= S_RELEASE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lw_sha_core_arbiter.sv
// Directed self-checking bench for lw_sha_core_arbiter (N_REQ=2, ARCH_SZ=32, TIMEOUT=8).
module tb_lw_sha_core_arbiter;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned ARCH_SZ = 32;
  localparam int unsigned TIMEOUT = 8;

  logic                     clk_i;
  logic                     rst_i;
  logic [N_REQ-1:0]         req_i, gnt_o, start_i, valid_i, last_i, abort_i;
  logic [N_REQ*ARCH_SZ-1:0] data_i;
  logic [N_REQ*4-1:0]       opcode_i;
  logic [N_REQ-1:0]         ready_o, done_o, err_o;
  logic                     core_start_o, core_valid_o, core_last_o, core_abort_o;
  logic [ARCH_SZ-1:0]       core_data_o;
  logic [3:0]               core_opcode_o;
  logic                     core_ready_i, core_idle_i, core_done_i;

  int checks = 0;
  int errors = 0;

  lw_sha_core_arbiter #(.N_REQ(N_REQ), .ARCH_SZ(ARCH_SZ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .start_i(start_i), .valid_i(valid_i), .last_i(last_i), .abort_i(abort_i),
    .data_i(data_i), .opcode_i(opcode_i), .ready_o(ready_o), .done_o(done_o),
    .err_o(err_o), .core_start_o(core_start_o), .core_valid_o(core_valid_o),
    .core_last_o(core_last_o), .core_abort_o(core_abort_o), .core_data_o(core_data_o),
    .core_opcode_o(core_opcode_o), .core_ready_i(core_ready_i),
    .core_idle_i(core_idle_i), .core_done_i(core_done_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int r, input int k);
    return 32'h1000_0000 * 32'(r + 1) + 32'(k);
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Expects the DUT to have just granted requester r; runs one message to release.
  task automatic do_msg(input int r, input int nw, input int dly);
    logic [1:0] oh;
    oh = 2'(1 << r);
    check("msg_gnt", 64'(gnt_o), 64'(oh));
    start_i = oh; core_idle_i = 1'b1; #1;
    check("msg_start", 64'(core_start_o), 64'd1);
    tick();
    start_i = '0;
    for (int k = 0; k < nw; k++) begin
      valid_i = 2'b11;
      data_i = {exp_word(1, k), exp_word(0, k)};
      last_i = (k == nw - 1) ? oh : 2'b00;
      core_ready_i = 1'b1; #1;
      check("msg_data", 64'(core_data_o), 64'(exp_word(r, k)));
      check("msg_ready", 64'(ready_o), 64'(oh));
      check("msg_last", 64'(core_last_o), (k == nw - 1) ? 64'd1 : 64'd0);
      tick();
    end
    valid_i = '0; last_i = '0; core_ready_i = 1'b0;
    repeat (dly) tick();
    core_done_i = 1'b1; #1;
    check("msg_no_early_done", 64'(done_o), 64'd0);
    tick();
    core_done_i = 1'b0;
    check("msg_done", 64'(done_o), 64'(oh));
    check("msg_release_gnt", 64'(gnt_o), 64'd0);
    tick();
  endtask

  initial begin
    rst_i = 1'b1; req_i = 2'b11; start_i = '0; valid_i = '0; last_i = '0; abort_i = '0;
    data_i = '0; opcode_i = 8'h5A; core_ready_i = 1'b0; core_idle_i = 1'b1; core_done_i = 1'b0;

    // Reset
    tick(); tick();
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_core", 64'({core_start_o, core_valid_o, core_last_o, core_abort_o}), 64'd0);
    check("rst_core_data", 64'(core_data_o), 64'd0);
    req_i = '0;
    rst_i = 1'b0;
    tick();

    // Single requester, 16 words, done 20 cycles after start
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    check("single_opcode", 64'(core_opcode_o), 64'hA);
    do_msg(0, 16, 3);
    check("single_idle_gnt", 64'(gnt_o), 64'd0);

    // Contention from a fresh pointer: 01, 10, 01
    do_reset();
    req_i = 2'b11;
    tick();
    do_msg(0, 3, 0);
    do_msg(1, 3, 0);
    req_i = 2'b00;
    do_msg(0, 3, 0);
    check("cont_idle_gnt", 64'(gnt_o), 64'd0);

    // Abort from requester 1 after word 5; release waits for core_idle_i
    req_i = 2'b10;
    tick();
    req_i = 2'b00;
    check("abort_gnt", 64'(gnt_o), 64'd2);
    start_i = 2'b10; #1;
    tick();
    start_i = '0;
    for (int k = 0; k < 5; k++) begin
      valid_i = 2'b10; core_ready_i = 1'b1;
      data_i = {exp_word(1, k), exp_word(0, k)}; #1;
      check("abort_data", 64'(core_data_o), 64'(exp_word(1, k)));
      tick();
    end
    valid_i = '0; core_ready_i = 1'b0;
    abort_i = 2'b10; core_idle_i = 1'b0; #1;
    check("abort_fwd", 64'(core_abort_o), 64'd1);
    tick();
    check("abort_once", 64'(core_abort_o), 64'd0);
    check("abort_hold_gnt", 64'(gnt_o), 64'd2);
    tick();
    abort_i = '0;
    check("abort_wait_gnt", 64'(gnt_o), 64'd2);
    check("abort_no_done", 64'(done_o), 64'd0);
    check("abort_no_err", 64'(err_o), 64'd0);
    core_idle_i = 1'b1;
    tick();
    check("abort_release_gnt", 64'(gnt_o), 64'd0);
    check("abort_release_done", 64'(done_o), 64'd0);
    tick();

    // Collision: done and abort together, done wins
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    check("coll_gnt", 64'(gnt_o), 64'd1);
    start_i = 2'b01; #1;
    tick();
    start_i = '0;
    core_done_i = 1'b1; abort_i = 2'b01; #1;
    check("coll_abort_low", 64'(core_abort_o), 64'd0);
    tick();
    core_done_i = 1'b0; abort_i = '0;
    check("coll_done", 64'(done_o), 64'd1);
    check("coll_gnt_rel", 64'(gnt_o), 64'd0);
    tick();

    // Reset in BUSY
    req_i = 2'b10;
    tick();
    req_i = 2'b00;
    start_i = 2'b10; #1;
    tick();
    start_i = '0;
    valid_i = 2'b10; core_ready_i = 1'b1; #1;
    check("rstbusy_valid", 64'(core_valid_o), 64'd1);
    rst_i = 1'b1;
    tick();
    check("rstbusy_gnt", 64'(gnt_o), 64'd0);
    check("rstbusy_valid_low", 64'(core_valid_o), 64'd0);
    check("rstbusy_ready", 64'(ready_o), 64'd0);
    rst_i = 1'b0; valid_i = '0; core_ready_i = 1'b0;
    tick();

`ifdef LW_SHA_ARB_WATCHDOG_EN
    // Watchdog: abort 8 BUSY cycles after the last accepted word
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    check("wd_gnt", 64'(gnt_o), 64'd1);
    start_i = 2'b01; #1;
    tick();
    start_i = '0;
    valid_i = 2'b01; core_ready_i = 1'b1; #1;
    tick();
    valid_i = '0; core_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("wd_quiet", 64'(core_abort_o), 64'd0);
      tick();
    end
    check("wd_abort", 64'(core_abort_o), 64'd1);
    check("wd_err_pending", 64'(err_o), 64'd0);
    tick();
    check("wd_err", 64'(err_o), 64'd1);
    check("wd_abort_once", 64'(core_abort_o), 64'd0);
    tick();
    check("wd_err_once", 64'(err_o), 64'd0);
    check("wd_release", 64'(gnt_o), 64'd0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
